axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple command/response handshake into AXI4-Lite read and write transactions. It drives the master side of the bridge's AXI-Lite interface and serves as the system-side driver and bench traffic source for the AXI4-Lite-to-APB bridge. Only one transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and the s_axi_araddr/s_axi_awaddr buses.
- DATA_WIDTH, 32, data width; must be 32 or 64. Strobe width is DATA_WIDTH/8.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transaction address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- cmd_prot  in  3  driven onto arprot or awprot.
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  client accepts the completion.
- rsp_write  out  1  completed transaction was a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- s_axi_araddr, s_axi_arvalid, s_axi_arprot  out  ADDR_WIDTH/1/3  read address channel.
- s_axi_arready  in  1
- s_axi_rdata, s_axi_rresp, s_axi_rvalid  in  DATA_WIDTH/2/1
- s_axi_rready  out  1
- s_axi_awaddr, s_axi_awvalid, s_axi_awprot  out  ADDR_WIDTH/1/3  write address channel.
- s_axi_awready  in  1
- s_axi_wdata, s_axi_wstrb, s_axi_wvalid  out  DATA_WIDTH/(DATA_WIDTH/8)/1  write data channel.
- s_axi_wready  in  1
- s_axi_bresp, s_axi_bvalid  in  2/1
- s_axi_bready  out  1

Behaviour:
- All outputs are registered. While s_axi_aresetn is low, every valid and ready output is 0 and every data, address and resp output is 0. This takes effect immediately, independent of the clock.
- A reset mid-transaction abandons the transaction and the FSM returns to IDLE. No response is generated for the abandoned transaction.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, the FSM latches addr, wdata, wstrb, prot and write.
  - Write: go to WR_REQ, asserting awvalid and wvalid in the next cycle (cycle+1).
  - Read: go to RD_REQ, asserting arvalid in cycle+1.
- WR_REQ:
  - awvalid and wvalid are raised together.
  - Each valid drops in the cycle after its own handshake. Either order is legal, and both handshakes may occur in the same cycle.
  - A valid never drops before its handshake, and address/data stay stable while the valid is high.
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, capture bresp, set rdata=0, and go to RSP.
  - A bvalid arriving before both AW and W handshakes complete is ignored (bready is 0 in WR_REQ).
- RD_REQ: arvalid=1 until the arready handshake, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
- RSP:
  - rsp_valid=1, with rsp_write/rsp_rdata/rsp_resp held stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until the FSM is back in IDLE. Back-to-back commands therefore have a one-cycle IDLE gap.
- Minimum latency with zero-wait-state slave responses (cmd handshake at cycle 0):
  - Write: awvalid/wvalid at cycle 1, bready at cycle 2, rsp_valid at cycle 3.
  - Read: arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- Response codes are passed through unmodified (OKAY=00, SLVERR=10, DECERR=11). Error responses are not retried.
- The FSM never asserts the read and write channels simultaneously.

Optional Feature:
- Macro: AXIL_MST_STATS_EN.
- When defined, three extra outputs are added:
  - stat_wr_cnt [15:0]: completed writes.
  - stat_rd_cnt [15:0]: completed reads.
  - stat_err_cnt [15:0]: completions with resp[1]=1.
- Each counter increments by 1 in the cycle after its B or R handshake, saturates at 16'hFFFF, and resets to 0.
- A 1-cycle input stat_clr zeroes all three counters. If stat_clr coincides with an increment, the clear wins.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Write cmd addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF; slave ready immediately with bresp=00 -> awaddr=0x10, wdata=0xDEADBEEF and wstrb=0xF on the bus at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read cmd addr=0x24; slave holds arready low 4 cycles, then rdata=0x1234_5678, rresp=00 -> arvalid and araddr stable for 5 cycles; rsp_rdata=0x12345678, rsp_write=0.
- Write with awready at cycle 1 and wready delayed to cycle 4 -> awvalid drops at cycle 2; wvalid high cycles 1-4; bready first asserted at cycle 5.
- Read returning rresp=10 with rsp_ready held low 3 cycles -> rsp_valid and rsp_resp=10 stable 4 cycles; cmd_ready=0 until IDLE; with AXIL_MST_STATS_EN, stat_err_cnt=1 and stat_rd_cnt=1.
- Assert s_axi_aresetn low during WR_REQ -> awvalid/wvalid drop asynchronously; after release, cmd_ready=1 and no rsp_valid is produced.
- With AXIL_MST_STATS_EN: force stat_wr_cnt to 0xFFFF, then do one more write -> counter stays 0xFFFF; stat_clr -> 0.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command/response handshake in, AXI4-Lite master out.
// Define AXIL_MST_STATS_EN to add saturating write/read/error completion counters.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
`ifdef AXIL_MST_STATS_EN
    input  logic                    stat_clr,
    output logic [15:0]             stat_wr_cnt,
    output logic [15:0]             stat_rd_cnt,
    output logic [15:0]             stat_err_cnt,
`endif
    output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                    s_axi_arvalid,
    output logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arready,
    input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
    input  logic [1:0]              s_axi_rresp,
    input  logic                    s_axi_rvalid,
    output logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    output logic                    s_axi_awvalid,
    output logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awready,
    output logic [DATA_WIDTH-1:0]   s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                    s_axi_wvalid,
    input  logic                    s_axi_wready,
    input  logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_bvalid,
    output logic                    s_axi_bready
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [2:0]            awprot_q, awprot_d, arprot_q, arprot_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  b_hs, r_hs;

    assign b_hs = (state_q == WR_RESP) && s_axi_bvalid && bready_q;
    assign r_hs = (state_q == RD_DATA) && s_axi_rvalid && rready_q;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awprot_d    = awprot_q;
        arprot_d    = arprot_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        awprot_d  = cmd_prot;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arprot_d  = cmd_prot;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; a lowered valid marks its channel done.
                if (awvalid_q && s_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && s_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || s_axi_awready) && (!wvalid_q || s_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = s_axi_bresp;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && s_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = s_axi_rdata;
                    rsp_resp_d  = s_axi_rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awprot_q    <= '0;
            arprot_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awprot_q    <= awprot_d;
            arprot_q    <= arprot_d;
        end
    end

`ifdef AXIL_MST_STATS_EN
    logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (stat_clr) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (b_hs && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (r_hs && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (((b_hs && s_axi_bresp[1]) || (r_hs && s_axi_rresp[1])) && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign s_axi_araddr  = araddr_q;
    assign s_axi_arvalid = arvalid_q;
    assign s_axi_arprot  = arprot_q;
    assign s_axi_rready  = rready_q;
    assign s_axi_awaddr  = awaddr_q;
    assign s_axi_awvalid = awvalid_q;
    assign s_axi_awprot  = awprot_q;
    assign s_axi_wdata   = wdata_q;
    assign s_axi_wstrb   = wstrb_q;
    assign s_axi_wvalid  = wvalid_q;
    assign s_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed + randomized bench for axi_lite_master; expected cycle-by-cycle bus activity is
// derived from handshake timing rules, slave delays and a counter model.
module tb_axi_lite_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready, awvalid, awready;
    logic          wvalid, wready, bvalid, bready;
    logic [2:0]    arprot, awprot;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic [SW-1:0] wstrb;
`ifdef AXIL_MST_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXIL_MST_STATS_EN
        .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
        .stat_err_cnt(stat_err_cnt),
`endif
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arprot(arprot),
        .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awprot(awprot),
        .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump(input bit wr, input logic [1:0] resp);
        if (wr) exp_wr = (exp_wr == 65535) ? 65535 : exp_wr + 1;
        else    exp_rd = (exp_rd == 65535) ? 65535 : exp_rd + 1;
        if (resp[1]) exp_err = (exp_err == 65535) ? 65535 : exp_err + 1;
    endtask

    task automatic check_stats();
`ifdef AXIL_MST_STATS_EN
        chk("stat_wr", 64'(stat_wr_cnt), 64'(exp_wr));
        chk("stat_rd", 64'(stat_rd_cnt), 64'(exp_rd));
        chk("stat_err", 64'(stat_err_cnt), 64'(exp_err));
`endif
    endtask

    task automatic scramble_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rsp_ready = 1'b0; bresp = 2'($urandom); rresp = 2'($urandom); rdata = $urandom;
    endtask

    // Cycle 0 is the cmd handshake cycle; cycle c is sampled/driven at its negedge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] p,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input int r_dly, input logic [1:0] resp, input bit b_early);
        int aw_hs, w_hs, bf, b_start, b_hs, rf, rh;
        aw_hs   = 1 + aw_dly;
        w_hs    = 1 + w_dly;
        bf      = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
        b_start = b_early ? 1 : bf + b_dly;
        b_hs    = (b_start > bf) ? b_start : bf;
        rf      = b_hs + 1;
        rh      = rf + r_dly;
        @(negedge clk);
        chk("wr_cmd_ready0", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
        cmd_wstrb = s; cmd_prot = p;
        for (int c = 1; c <= rh + 1; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            scramble_cmd();
            chk("wr_awvalid", 64'(awvalid), 64'(c <= aw_hs));
            chk("wr_wvalid", 64'(wvalid), 64'(c <= w_hs));
            chk("wr_bready", 64'(bready), 64'(c >= bf && c <= b_hs));
            chk("wr_rsp_valid", 64'(rsp_valid), 64'(c >= rf && c <= rh));
            chk("wr_cmd_ready", 64'(cmd_ready), 64'(c > rh));
            chk("wr_no_read", 64'({arvalid, rready}), 64'd0);
            if (c <= aw_hs) begin
                chk("wr_awaddr", 64'(awaddr), 64'(a));
                chk("wr_awprot", 64'(awprot), 64'(p));
            end
            if (c <= w_hs) begin
                chk("wr_wdata", 64'(wdata), 64'(d));
                chk("wr_wstrb", 64'(wstrb), 64'(s));
            end
            if (c >= rf && c <= rh) begin
                chk("wr_rsp_write", 64'(rsp_write), 64'd1);
                chk("wr_rsp_resp", 64'(rsp_resp), 64'(resp));
                chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
            end
            slave_idle();
            awready   = (c == aw_hs);
            wready    = (c == w_hs);
            bvalid    = (c >= b_start && c <= b_hs);
            if (bvalid) bresp = resp;
            rsp_ready = (c == rh);
        end
        bump(1'b1, resp);
        check_stats();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p,
                           input int ar_dly, input int r_dly, input int rs_dly,
                           input logic [DW-1:0] d, input logic [1:0] resp);
        int ar_hs, rf, r_hs, sf, sh;
        ar_hs = 1 + ar_dly;
        rf    = ar_hs + 1;
        r_hs  = rf + r_dly;
        sf    = r_hs + 1;
        sh    = sf + rs_dly;
        @(negedge clk);
        chk("rd_cmd_ready0", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_prot = p;
        for (int c = 1; c <= sh + 1; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            scramble_cmd();
            chk("rd_arvalid", 64'(arvalid), 64'(c <= ar_hs));
            chk("rd_rready", 64'(rready), 64'(c >= rf && c <= r_hs));
            chk("rd_rsp_valid", 64'(rsp_valid), 64'(c >= sf && c <= sh));
            chk("rd_cmd_ready", 64'(cmd_ready), 64'(c > sh));
            chk("rd_no_write", 64'({awvalid, wvalid, bready}), 64'd0);
            if (c <= ar_hs) begin
                chk("rd_araddr", 64'(araddr), 64'(a));
                chk("rd_arprot", 64'(arprot), 64'(p));
            end
            if (c >= sf && c <= sh) begin
                chk("rd_rsp_write", 64'(rsp_write), 64'd0);
                chk("rd_rsp_resp", 64'(rsp_resp), 64'(resp));
                chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(d));
            end
            slave_idle();
            arready   = (c == ar_hs);
            rvalid    = (c == r_hs);
            if (rvalid) begin rdata = d; rresp = resp; end
            rsp_ready = (c == sh);
        end
        bump(1'b0, resp);
        check_stats();
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 1'b0;
        scramble_cmd();
        slave_idle();
`ifdef AXIL_MST_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valids", 64'({cmd_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        chk("rst_addr", 64'({araddr, awaddr}), 64'd0);
        chk("rst_data", 64'({wdata, rsp_rdata}), 64'd0);
        chk("rst_misc", 64'({wstrb, arprot, awprot, rsp_resp, rsp_write}), 64'd0);
        check_stats();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write, arready held off 4 cycles, delayed W, error read with stalled rsp_ready.
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0, 0, 2'b00, 1'b0);
        do_read(32'h0000_0024, 3'd0, 4, 0, 0, 32'h1234_5678, 2'b00);
        do_write(32'h0000_0030, 32'hA5A5_5A5A, 4'h3, 3'd2, 0, 3, 0, 0, 2'b00, 1'b0);
        do_read(32'h0000_0040, 3'd1, 0, 1, 3, 32'hCAFE_F00D, 2'b10);
        do_write(32'h0000_0050, 32'h0BAD_F00D, 4'h8, 3'd5, 2, 0, 1, 1, 2'b11, 1'b0);
        do_write(32'h0000_0060, 32'h1111_2222, 4'hC, 3'd7, 1, 3, 0, 0, 2'b10, 1'b1);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, $urandom, 4'($urandom), 3'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                         $urandom_range(0, 2), 2'($urandom), 1'($urandom));
            else
                do_read($urandom, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 2), $urandom, 2'($urandom));
        end

        // Reset in the middle of a write request phase.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h77; cmd_wdata = 32'h99;
        cmd_wstrb = 4'hF; cmd_prot = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_awvalid_before_rst", 64'({awvalid, wvalid}), 64'd3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valids", 64'({awvalid, wvalid, cmd_ready, rsp_valid}), 64'd0);
        chk("mid_rst_awaddr", 64'(awaddr), 64'd0);
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        bvalid = 1'b1; bresp = 2'b00; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_mid_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("post_mid_quiet", 64'({rsp_valid, awvalid, wvalid, bready}), 64'd0);
        end
        slave_idle();
        check_stats();
        do_read(32'h0000_0080, 3'd0, 0, 0, 0, 32'h5555_AAAA, 2'b00);

`ifdef AXIL_MST_STATS_EN
        @(negedge clk);
        force dut.wr_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.wr_cnt_q;
        exp_wr = 65535;
        do_write(32'h90, 32'h1, 4'h1, 3'd0, 0, 0, 0, 0, 2'b10, 1'b0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        check_stats();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
